lbp_image_host: RTL and testbench

//  Memory-side partner of the LBP engine. Loads a 128x128 8-bit gray image from a byte stream,

---
 rtl/lbp_image_host.sv | 136 +++++++++++++
 tb/tb_lbp_image_host.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lbp_image_host.sv
// lbp_image_host: memory-side partner of the LBP engine.
// Loads a gray frame from a byte stream, serves engine reads, captures LBP
// writes, then streams the LBP frame out in raster order.
module lbp_image_host #(
  parameter int ADDR_W  = 14,
  parameter int DATA_W  = 8,
  parameter int IMG_PIX = 16384
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  input  logic [ADDR_W-1:0] gray_addr,
  input  logic              gray_req,
  output logic              gray_ready,
  output logic [DATA_W-1:0] gray_data,
  input  logic [ADDR_W-1:0] lbp_addr,
  input  logic              lbp_valid,
  input  logic [DATA_W-1:0] lbp_data,
  input  logic              finish,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic [ADDR_W:0]   wr_count,
  output logic              proto_err,
  output logic              done
);

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_SERVE,
    ST_READOUT,
    ST_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(IMG_PIX - 1);
  localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(IMG_PIX);

  state_t            state;
  logic [ADDR_W-1:0] ld_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [DATA_W-1:0] gray_mem [IMG_PIX];
  logic [DATA_W-1:0] lbp_mem  [IMG_PIX];

  logic              gray_we;
  logic              lbp_we;
  logic [ADDR_W:0]   wr_count_nxt;
  logic              proto_hit;

  assign gray_we = (state == ST_LOAD) && load_valid;
  assign lbp_we  = (state == ST_SERVE) && lbp_valid;

  // Write counter including this edge's write; the finish check uses it so a
  // write landing on the finish edge is counted before the transition.
  always_comb begin
    wr_count_nxt = wr_count;
    if (lbp_we && (wr_count != '1)) wr_count_nxt = wr_count + 1'b1;
  end

  // Protocol violations by state; DONE ignores the engine entirely.
  always_comb begin
    proto_hit = 1'b0;
    case (state)
      ST_LOAD:    proto_hit = gray_req | lbp_valid | finish;
      ST_SERVE:   proto_hit = finish && (wr_count_nxt != FULL_COUNT);
      ST_READOUT: proto_hit = gray_req | lbp_valid;
      default:    proto_hit = 1'b0;
    endcase
  end

  // Gray image store, written only while loading (never cleared by reset).
  always_ff @(posedge clk) begin
    if (gray_we) gray_mem[ld_ptr] <= load_data;
  end

  // LBP result store, written only while serving (never cleared by reset).
  always_ff @(posedge clk) begin
    if (lbp_we) lbp_mem[lbp_addr] <= lbp_data;
  end

  // Frame sequencer with registered handshake/status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_LOAD;
      load_ready <= 1'b1;
      gray_ready <= 1'b0;
      out_valid  <= 1'b0;
      done       <= 1'b0;
      proto_err  <= 1'b0;
      wr_count   <= '0;
      ld_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      if (proto_hit) proto_err <= 1'b1;
      wr_count <= wr_count_nxt;
      case (state)
        ST_LOAD: begin
          if (load_valid) begin
            ld_ptr <= ld_ptr + 1'b1;
            if (ld_ptr == LAST_ADDR) begin
              state      <= ST_SERVE;
              load_ready <= 1'b0;
              gray_ready <= 1'b1;
            end
          end
        end
        ST_SERVE: begin
          if (finish) begin
            state      <= ST_READOUT;
            gray_ready <= 1'b0;
            out_valid  <= 1'b1;
          end
        end
        ST_READOUT: begin
          if (out_ready) begin
            rd_ptr <= rd_ptr + 1'b1;
            if (rd_ptr == LAST_ADDR) begin
              state     <= ST_DONE;
              out_valid <= 1'b0;
              done      <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Zero-latency read port: the engine samples on the edge it moves gray_addr.
  assign gray_data = (state == ST_SERVE && gray_req) ? gray_mem[gray_addr] : '0;
  assign out_data  = lbp_mem[rd_ptr];
  assign out_last  = out_valid && (rd_ptr == LAST_ADDR);

endmodule

// File: tb/tb_lbp_image_host.sv
// Directed testbench for lbp_image_host: ramp image load, engine read/write
// traffic, back-pressured readout, protocol errors and mid-frame reset.
module tb_lbp_image_host;
  localparam int ADDR_W  = 14;
  localparam int DATA_W  = 8;
  localparam int IMG_PIX = 16384;

  logic              clk;
  logic              reset;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_ready;
  logic [ADDR_W-1:0] gray_addr;
  logic              gray_req;
  logic              gray_ready;
  logic [DATA_W-1:0] gray_data;
  logic [ADDR_W-1:0] lbp_addr;
  logic              lbp_valid;
  logic [DATA_W-1:0] lbp_data;
  logic              finish;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_ready;
  logic [ADDR_W:0]   wr_count;
  logic              proto_err;
  logic              done;

  int vectors = 0;
  int miscompares = 0;
  logic [DATA_W-1:0] gold [IMG_PIX];

  lbp_image_host #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .IMG_PIX(IMG_PIX)) dut (
    .clk(clk), .reset(reset),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .gray_addr(gray_addr), .gray_req(gray_req), .gray_ready(gray_ready),
    .gray_data(gray_data),
    .lbp_addr(lbp_addr), .lbp_valid(lbp_valid), .lbp_data(lbp_data),
    .finish(finish),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready),
    .wr_count(wr_count), .proto_err(proto_err), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ramp image: pixel value is the low byte of the raster address.
  function automatic logic [7:0] pix(input int a);
    logic [31:0] t;
    t = a;
    return t[7:0];
  endfunction

  // Reference LBP: border pixels 0; bit n set when neighbour n >= centre,
  // neighbours in raster order around the centre.
  function automatic logic [7:0] lbp_of(input int a);
    int r, c, n;
    logic [7:0] res;
    r = a / 128;
    c = a % 128;
    res = '0;
    if (r == 0 || r == 127 || c == 0 || c == 127) return 8'h00;
    n = 0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if (!(dr == 0 && dc == 0)) begin
          if (pix(a + dr * 128 + dc) >= pix(a)) res[n] = 1'b1;
          n++;
        end
      end
    end
    return res;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    load_valid = 1'b0; load_data = '0;
    gray_req = 1'b0;   gray_addr = '0;
    lbp_valid = 1'b0;  lbp_addr = '0; lbp_data = '0;
    finish = 1'b0;     out_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    tick();
  endtask

  task automatic load_bytes(input int first, input int count);
    for (int i = first; i < first + count; i++) begin
      load_valid = 1'b1;
      load_data  = pix(i);
      tick();
    end
    load_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #2;
    vectors++; if (load_ready !== 1'b1) begin miscompares++; $display("FAIL reset_load_ready: got %b expected 1", load_ready); end
    vectors++; if (gray_ready !== 1'b0) begin miscompares++; $display("FAIL reset_gray_ready: got %b expected 0", gray_ready); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    vectors++; if (out_last !== 1'b0) begin miscompares++; $display("FAIL reset_out_last: got %b expected 0", out_last); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", done); end
    vectors++; if (proto_err !== 1'b0) begin miscompares++; $display("FAIL reset_proto_err: got %b expected 0", proto_err); end
    vectors++; if (wr_count !== 15'd0) begin miscompares++; $display("FAIL reset_wr_count: got %0d expected 0", wr_count); end
    vectors++; if (gray_data !== 8'h00) begin miscompares++; $display("FAIL reset_gray_data: got %h expected 00", gray_data); end
  endtask

  // lbp_valid during LOAD flags an error, is dropped and does not disturb loading.
  task automatic test_proto_load_write();
    lbp_valid = 1'b1; lbp_addr = 14'd7; lbp_data = 8'h99;
    tick();
    lbp_valid = 1'b0;
    #2;
    vectors++; if (proto_err !== 1'b1) begin miscompares++; $display("FAIL load_write_proto_err: got %b expected 1", proto_err); end
    vectors++; if (wr_count !== 15'd0) begin miscompares++; $display("FAIL load_write_dropped: got %0d expected 0", wr_count); end
    vectors++; if (load_ready !== 1'b1) begin miscompares++; $display("FAIL load_write_still_load: got %b expected 1", load_ready); end
    load_bytes(0, IMG_PIX);
    #2;
    vectors++; if (gray_ready !== 1'b1) begin miscompares++; $display("FAIL load_write_serve: got %b expected 1", gray_ready); end
    vectors++; if (proto_err !== 1'b1) begin miscompares++; $display("FAIL load_write_sticky: got %b expected 1", proto_err); end
  endtask

  task automatic test_reset_mid_serve();
    for (int k = 0; k < 5000; k++) begin
      gray_req = 1'b1; gray_addr = ADDR_W'(k);
      lbp_valid = 1'b1; lbp_addr = ADDR_W'(k); lbp_data = 8'hA5;
      tick();
    end
    idle_inputs();
    #2;
    vectors++; if (wr_count !== 15'd5000) begin miscompares++; $display("FAIL mid_serve_wr_count: got %0d expected 5000", wr_count); end
    vectors++; if (proto_err !== 1'b1) begin miscompares++; $display("FAIL mid_serve_sticky: got %b expected 1", proto_err); end
    reset = 1'b1;
    #1;
    vectors++; if (gray_ready !== 1'b0) begin miscompares++; $display("FAIL async_reset_gray_ready: got %b expected 0", gray_ready); end
    vectors++; if (wr_count !== 15'd0) begin miscompares++; $display("FAIL async_reset_wr_count: got %0d expected 0", wr_count); end
    tick();
    reset = 1'b0;
    #2;
    vectors++; if (load_ready !== 1'b1) begin miscompares++; $display("FAIL mid_reset_load_ready: got %b expected 1", load_ready); end
    vectors++; if (gray_ready !== 1'b0) begin miscompares++; $display("FAIL mid_reset_gray_ready: got %b expected 0", gray_ready); end
    vectors++; if (wr_count !== 15'd0) begin miscompares++; $display("FAIL mid_reset_wr_count: got %0d expected 0", wr_count); end
    vectors++; if (proto_err !== 1'b0) begin miscompares++; $display("FAIL mid_reset_proto_err: got %b expected 0", proto_err); end
    tick();
  endtask

  task automatic test_load_ramp();
    load_bytes(0, IMG_PIX - 1);
    #2;
    vectors++; if (gray_ready !== 1'b0) begin miscompares++; $display("FAIL ramp_early_gray_ready: got %b expected 0", gray_ready); end
    vectors++; if (load_ready !== 1'b1) begin miscompares++; $display("FAIL ramp_early_load_ready: got %b expected 1", load_ready); end
    load_valid = 1'b1; load_data = 8'hFF;
    tick();
    load_valid = 1'b0;
    #2;
    vectors++; if (gray_ready !== 1'b1) begin miscompares++; $display("FAIL ramp_gray_ready: got %b expected 1", gray_ready); end
    vectors++; if (load_ready !== 1'b0) begin miscompares++; $display("FAIL ramp_load_ready: got %b expected 0", load_ready); end
    tick();
  endtask

  task automatic test_gray_read();
    logic [ADDR_W-1:0] ra [5];
    logic [DATA_W-1:0] rd [5];
    ra[0] = 14'd300;   rd[0] = 8'h2C;
    ra[1] = 14'd0;     rd[1] = 8'h00;
    ra[2] = 14'd16383; rd[2] = 8'hFF;
    ra[3] = 14'd129;   rd[3] = 8'h81;
    ra[4] = 14'd5000;  rd[4] = 8'h88;
    for (int i = 0; i < 5; i++) begin
      gray_req = 1'b1; gray_addr = ra[i];
      #2;
      vectors++; if (gray_data !== rd[i]) begin miscompares++; $display("FAIL gray_read[%0d]: got %h expected %h", ra[i], gray_data, rd[i]); end
      gray_req = 1'b0;
      #2;
      vectors++; if (gray_data !== 8'h00) begin miscompares++; $display("FAIL gray_idle[%0d]: got %h expected 00", ra[i], gray_data); end
    end
    tick();
    vectors++; if (proto_err !== 1'b0) begin miscompares++; $display("FAIL gray_read_proto_err: got %b expected 0", proto_err); end
  endtask

  // Engine model: reads pixel k while writing the LBP of pixel k-129, whose
  // whole neighbourhood has been fetched by then.
  task automatic test_engine_run();
    for (int k = 0; k < IMG_PIX + 129; k++) begin
      gray_req  = (k < IMG_PIX);
      gray_addr = ADDR_W'(k);
      lbp_valid = (k >= 129);
      lbp_addr  = ADDR_W'(k - 129);
      lbp_data  = (k >= 129) ? gold[k - 129] : 8'h00;
      #2;
      if (k < IMG_PIX) begin
        vectors++; if (gray_data !== pix(k)) begin miscompares++; $display("FAIL engine_read[%0d]: got %h expected %h", k, gray_data, pix(k)); end
      end
      @(posedge clk);
      #1;
    end
    idle_inputs();
    #2;
    vectors++; if (wr_count !== 15'd16384) begin miscompares++; $display("FAIL engine_wr_count: got %0d expected 16384", wr_count); end
    vectors++; if (proto_err !== 1'b0) begin miscompares++; $display("FAIL engine_proto_err: got %b expected 0", proto_err); end
    finish = 1'b1;
    tick();
    finish = 1'b0;
    #2;
    vectors++; if (gray_ready !== 1'b0) begin miscompares++; $display("FAIL finish_gray_ready: got %b expected 0", gray_ready); end
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL finish_out_valid: got %b expected 1", out_valid); end
    vectors++; if (proto_err !== 1'b0) begin miscompares++; $display("FAIL finish_proto_err: got %b expected 0", proto_err); end
  endtask

  // Readout with out_ready cycling 1,0,0,1 at first, then streaming.
  task automatic test_readout();
    int idx, cyc;
    logic rdy, exp_last;
    idx = 0;
    cyc = 0;
    while (idx < IMG_PIX && cyc < 40000) begin
      rdy = (cyc < 256) ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
      out_ready = rdy;
      exp_last = (idx == IMG_PIX - 1);
      #2;
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL readout_valid[%0d]: got %b expected 1", idx, out_valid); end
      vectors++; if (out_data !== gold[idx]) begin miscompares++; $display("FAIL readout_data[%0d]: got %h expected %h", idx, out_data, gold[idx]); end
      vectors++; if (out_last !== exp_last) begin miscompares++; $display("FAIL readout_last[%0d]: got %b expected %b", idx, out_last, exp_last); end
      @(posedge clk);
      #1;
      if (rdy) idx++;
      cyc++;
    end
    out_ready = 1'b0;
    vectors++; if (idx !== IMG_PIX) begin miscompares++; $display("FAIL readout_timeout: got %0d bytes expected %0d", idx, IMG_PIX); end
    #2;
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL readout_done: got %b expected 1", done); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL readout_end_valid: got %b expected 0", out_valid); end
    vectors++; if (out_last !== 1'b0) begin miscompares++; $display("FAIL readout_end_last: got %b expected 0", out_last); end
    // Engine traffic after completion is ignored.
    gray_req = 1'b1; lbp_valid = 1'b1; finish = 1'b1;
    #2;
    vectors++; if (gray_data !== 8'h00) begin miscompares++; $display("FAIL done_gray_data: got %h expected 00", gray_data); end
    tick();
    idle_inputs();
    #2;
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL done_held: got %b expected 1", done); end
    vectors++; if (proto_err !== 1'b0) begin miscompares++; $display("FAIL done_ignored: got %b expected 0", proto_err); end
  endtask

  task automatic test_finish_early();
    do_reset();
    load_bytes(0, IMG_PIX);
    for (int k = 0; k < 100; k++) begin
      lbp_valid = 1'b1; lbp_addr = ADDR_W'(k); lbp_data = 8'h3C;
      tick();
    end
    lbp_valid = 1'b0;
    #2;
    vectors++; if (wr_count !== 15'd100) begin miscompares++; $display("FAIL early_wr_count: got %0d expected 100", wr_count); end
    vectors++; if (proto_err !== 1'b0) begin miscompares++; $display("FAIL early_pre_proto_err: got %b expected 0", proto_err); end
    finish = 1'b1;
    tick();
    finish = 1'b0;
    #2;
    vectors++; if (proto_err !== 1'b1) begin miscompares++; $display("FAIL early_proto_err: got %b expected 1", proto_err); end
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL early_readout: got %b expected 1", out_valid); end
    repeat (3) tick();
    vectors++; if (proto_err !== 1'b1) begin miscompares++; $display("FAIL early_sticky: got %b expected 1", proto_err); end
    do_reset();
    vectors++; if (proto_err !== 1'b0) begin miscompares++; $display("FAIL early_cleared: got %b expected 0", proto_err); end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    for (int i = 0; i < IMG_PIX; i++) gold[i] = lbp_of(i);
    test_reset();
    test_proto_load_write();
    test_reset_mid_serve();
    test_load_ramp();
    test_gray_read();
    test_engine_run();
    test_readout();
    test_finish_early();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
